// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV64I decode stage.
//   fetch_data_t  : registered fetch output (pc, raw_instr, valid)
//   decode_op_t   : decoded operation, OP_UNKNOWN for anything unrecognised
//   control_t     : write-back / memory / operand-select controls
//   decode_data_t : decode pipeline register seen by execute
package decode_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // 6-bit shamt leaves funct6 for RV64 immediate shifts
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [5:0] {
    OP_UNKNOWN,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } decode_op_t;

  typedef struct packed {
    logic       regwrite;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       alu_src_imm;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
    decode_op_t  op;
    logic [4:0]  dst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] imm;
    control_t    ctl;
  } decode_data_t;

endpackage

// File: rtl/decode_decoder.sv
// Purely combinational RV64I instruction cracker.
//   raw_instr_i : 32-bit instruction
//   op_o        : decoded operation (OP_UNKNOWN if illegal)
//   ctl_o       : control fields
//   imm_o       : sign-extended immediate
//   ra1_o/ra2_o : source indices, 0 when the format has no such source
//   dst_o       : destination index, 0 when nothing is written
module decoder
  import decode_pkg::*;
(
  input  logic [31:0] raw_instr_i,
  output decode_op_t  op_o,
  output control_t    ctl_o,
  output logic [63:0] imm_o,
  output logic [4:0]  ra1_o,
  output logic [4:0]  ra2_o,
  output logic [4:0]  dst_o
);

  logic [31:0] ir;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use1, use2, wr;

  assign ir  = raw_instr_i;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{52{ir[31]}}, ir[31:20]};
  assign imm_s = {{52{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {{32{ir[31]}}, ir[31:12], 12'b0};
  assign imm_j = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    op_o  = OP_UNKNOWN;
    ctl_o = '0;
    imm_o = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    wr    = 1'b0;
    unique case (opc)
      OPC_LOAD: begin
        use1 = 1'b1; wr = 1'b1; imm_o = imm_i;
        ctl_o.mem_read = 1'b1; ctl_o.alu_src_imm = 1'b1;
        ctl_o.mem_size = f3[1:0]; ctl_o.mem_unsigned = f3[2];
        case (f3)
          3'd0: op_o = OP_LB;  3'd1: op_o = OP_LH;  3'd2: op_o = OP_LW;
          3'd3: op_o = OP_LD;  3'd4: op_o = OP_LBU; 3'd5: op_o = OP_LHU;
          3'd6: op_o = OP_LWU; default: op_o = OP_UNKNOWN;
        endcase
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1; imm_o = imm_s;
        ctl_o.mem_write = 1'b1; ctl_o.alu_src_imm = 1'b1; ctl_o.mem_size = f3[1:0];
        case (f3)
          3'd0: op_o = OP_SB; 3'd1: op_o = OP_SH; 3'd2: op_o = OP_SW; 3'd3: op_o = OP_SD;
          default: op_o = OP_UNKNOWN;
        endcase
      end
      OPC_OPIMM: begin
        use1 = 1'b1; wr = 1'b1; imm_o = imm_i; ctl_o.alu_src_imm = 1'b1;
        case (f3)
          F3_ADD:  op_o = OP_ADDI;
          F3_SLT:  op_o = OP_SLTI;
          F3_SLTU: op_o = OP_SLTIU;
          F3_XOR:  op_o = OP_XORI;
          F3_OR:   op_o = OP_ORI;
          F3_AND:  op_o = OP_ANDI;
          F3_SLL:  op_o = (ir[31:26] == F6_BASE) ? OP_SLLI : OP_UNKNOWN;
          default: op_o = (ir[31:26] == F6_BASE) ? OP_SRLI :
                          (ir[31:26] == F6_ALT)  ? OP_SRAI : OP_UNKNOWN;
        endcase
      end
      OPC_OPIMM32: begin
        use1 = 1'b1; wr = 1'b1; imm_o = imm_i; ctl_o.alu_src_imm = 1'b1;
        case (f3)
          F3_ADD:  op_o = OP_ADDIW;
          F3_SLL:  op_o = (f7 == F7_BASE) ? OP_SLLIW : OP_UNKNOWN;
          F3_SR:   op_o = (f7 == F7_BASE) ? OP_SRLIW :
                          (f7 == F7_ALT)  ? OP_SRAIW : OP_UNKNOWN;
          default: op_o = OP_UNKNOWN;
        endcase
      end
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD: op_o = OP_ADD;  F3_SLL:  op_o = OP_SLL;  F3_SLT: op_o = OP_SLT;
            F3_SLTU: op_o = OP_SLTU; F3_XOR: op_o = OP_XOR;  F3_SR:  op_o = OP_SRL;
            F3_OR:  op_o = OP_OR;   default: op_o = OP_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            F3_ADD:  op_o = OP_SUB;
            F3_SR:   op_o = OP_SRA;
            default: op_o = OP_UNKNOWN;
          endcase
        end
      end
      OPC_OP32: begin
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD: op_o = OP_ADDW; F3_SLL: op_o = OP_SLLW; F3_SR: op_o = OP_SRLW;
            default: op_o = OP_UNKNOWN;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            F3_ADD: op_o = OP_SUBW; F3_SR: op_o = OP_SRAW;
            default: op_o = OP_UNKNOWN;
          endcase
        end
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; imm_o = imm_b;
        case (f3)
          3'd0: op_o = OP_BEQ;  3'd1: op_o = OP_BNE;  3'd4: op_o = OP_BLT;
          3'd5: op_o = OP_BGE;  3'd6: op_o = OP_BLTU; 3'd7: op_o = OP_BGEU;
          default: op_o = OP_UNKNOWN;
        endcase
      end
      OPC_LUI:   begin wr = 1'b1; imm_o = imm_u; ctl_o.alu_src_imm = 1'b1; op_o = OP_LUI;   end
      OPC_AUIPC: begin wr = 1'b1; imm_o = imm_u; ctl_o.alu_src_imm = 1'b1; op_o = OP_AUIPC; end
      OPC_JAL:   begin wr = 1'b1; imm_o = imm_j; op_o = OP_JAL; end
      OPC_JALR: begin
        use1 = 1'b1; wr = 1'b1; imm_o = imm_i; ctl_o.alu_src_imm = 1'b1;
        op_o = (f3 == 3'd0) ? OP_JALR : OP_UNKNOWN;
      end
      default: op_o = OP_UNKNOWN;
    endcase

    // Illegal encodings must not touch state; execute traps on OP_UNKNOWN.
    if (op_o == OP_UNKNOWN) begin
      ctl_o = '0; imm_o = '0; use1 = 1'b0; use2 = 1'b0; wr = 1'b0;
    end

    ctl_o.regwrite = wr & (rd != 5'd0);
    ra1_o = use1 ? rs1 : 5'd0;
    ra2_o = use2 ? rs2 : 5'd0;
    // Stores/branches reuse rd bits for immediates, so dst is only meaningful on write.
    dst_o = ctl_o.regwrite ? rd : 5'd0;
  end

endmodule

// File: rtl/decode.sv
// RV64I decode stage: cracks dataF, registers the result into dataD and
// detects load-use hazards.
//   clk, reset     : clock, synchronous active-high reset
//   dataF          : registered fetch output
//   branch         : execute redirect, dataF is wrong-path
//   stope, stopm   : execute / memory stall, freeze dataD
//   ra1, ra2       : register-file read indices (combinational from dataF)
//   rd1, rd2       : register-file read data
//   stopd          : load-use stall request to fetch
//   dataD          : decoded instruction to execute
module decode
  import decode_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  fetch_data_t  dataF,
  input  logic         branch,
  input  logic         stope,
  input  logic         stopm,
  output logic [4:0]   ra1,
  output logic [4:0]   ra2,
  input  logic [63:0]  rd1,
  input  logic [63:0]  rd2,
  output logic         stopd,
  output decode_data_t dataD
);

  decode_data_t dataD_q, dataD_d;
  decode_op_t   dec_op;
  control_t     dec_ctl;
  logic [63:0]  dec_imm;
  logic [4:0]   dec_dst;
  logic         hazard;

  decoder u_decoder (
    .raw_instr_i (dataF.raw_instr),
    .op_o        (dec_op),
    .ctl_o       (dec_ctl),
    .imm_o       (dec_imm),
    .ra1_o       (ra1),
    .ra2_o       (ra2),
    .dst_o       (dec_dst)
  );

  always_comb begin
    dataD_d           = '0;
    dataD_d.pc        = dataF.pc;
    dataD_d.raw_instr = dataF.raw_instr;
    dataD_d.valid     = dataF.valid;
    dataD_d.op        = dec_op;
    dataD_d.dst       = dec_dst;
    dataD_d.ra1       = ra1;
    dataD_d.ra2       = ra2;
    dataD_d.src1      = rd1;
    dataD_d.src2      = rd2;
    dataD_d.imm       = dec_imm;
    dataD_d.ctl       = dec_ctl;
  end

  // Unused sources decode to x0, and dst!=0 keeps them from matching.
  assign hazard = dataF.valid & dataD_q.valid & dataD_q.ctl.mem_read &
                  (dataD_q.dst != 5'd0) &
                  ((dataD_q.dst == ra1) | (dataD_q.dst == ra2));
  assign stopd  = hazard & ~branch;

  // Bubbles only drop valid; the stale load fields are harmless since hazard is gated by valid.
  always_ff @(posedge clk) begin
    if (reset)               dataD_q       <= '0;
    else if (stope | stopm)  dataD_q       <= dataD_q;
    else if (branch)         dataD_q.valid <= 1'b0;
    else if (hazard)         dataD_q.valid <= 1'b0;
    else                     dataD_q       <= dataD_d;
  end

  assign dataD = dataD_q;

endmodule

// File: tb/tb_decode.sv
module tb_decode;
  import decode_pkg::*;

  logic         clk = 1'b0;
  logic         reset, branch, stope, stopm;
  fetch_data_t  dataF;
  logic [4:0]   ra1, ra2;
  logic [63:0]  rd1, rd2;
  logic         stopd;
  decode_data_t dataD;
  int errors = 0;
  int checks = 0;

  decode dut (
    .clk(clk), .reset(reset), .dataF(dataF), .branch(branch), .stope(stope),
    .stopm(stopm), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .stopd(stopd), .dataD(dataD)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] pc, input logic [31:0] ins, input logic v);
    dataF.pc = pc; dataF.raw_instr = ins; dataF.valid = v;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; put(64'h0, 32'h00500093, 1'b1);
    step(); step();
    checks++; if (dataD !== '0) begin errors++; $display("FAIL reset_dataD got=%h exp=0", dataD); end
    checks++; if (stopd !== 1'b0) begin errors++; $display("FAIL reset_stopd got=%b exp=0", stopd); end
    reset = 1'b0;
  endtask

  task automatic test_imm();
    rd1 = 64'hAAAA_0000_1111_2222; rd2 = 64'h5555;
    put(64'h1000, 32'h00500093, 1'b1);   // addi x1,x0,5
    checks++; if (ra1 !== 5'd0) begin errors++; $display("FAIL addi_ra1 got=%0d exp=0", ra1); end
    checks++; if (ra2 !== 5'd0) begin errors++; $display("FAIL addi_ra2 got=%0d exp=0", ra2); end
    step();
    checks++; if (dataD.op !== OP_ADDI) begin errors++; $display("FAIL addi_op got=%0d exp=%0d", dataD.op, OP_ADDI); end
    checks++; if (dataD.imm !== 64'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", dataD.imm); end
    checks++; if (dataD.dst !== 5'd1) begin errors++; $display("FAIL addi_dst got=%0d exp=1", dataD.dst); end
    checks++; if (dataD.ctl.regwrite !== 1'b1) begin errors++; $display("FAIL addi_regwrite got=%b exp=1", dataD.ctl.regwrite); end
    checks++; if (dataD.valid !== 1'b1 || dataD.pc !== 64'h1000) begin errors++; $display("FAIL addi_valid_pc got=%b/%h exp=1/1000", dataD.valid, dataD.pc); end
    checks++; if (dataD.src1 !== 64'hAAAA_0000_1111_2222) begin errors++; $display("FAIL addi_src1 got=%h exp=aaaa000011112222", dataD.src1); end

    put(64'h1004, 32'hFFF00093, 1'b1);   // addi x1,x0,-1
    step();
    checks++; if (dataD.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_neg_imm got=%h exp=ffffffffffffffff", dataD.imm); end

    put(64'h1008, 32'h12345137, 1'b1);   // lui x2,0x12345
    step();
    checks++; if (dataD.imm !== 64'h0000_0000_1234_5000 || dataD.op !== OP_LUI || dataD.dst !== 5'd2) begin
      errors++; $display("FAIL lui got=%h/%0d/%0d exp=12345000/%0d/2", dataD.imm, dataD.op, dataD.dst, OP_LUI); end

    put(64'h100C, 32'h80000137, 1'b1);   // lui x2,0x80000
    step();
    checks++; if (dataD.imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_sext got=%h exp=ffffffff80000000", dataD.imm); end

    put(64'h1010, 32'h0020B423, 1'b1);   // sd x2,8(x1)
    checks++; if (ra1 !== 5'd1 || ra2 !== 5'd2) begin errors++; $display("FAIL sd_ra got=%0d/%0d exp=1/2", ra1, ra2); end
    step();
    checks++; if (dataD.op !== OP_SD || dataD.imm !== 64'd8 || dataD.ctl.mem_write !== 1'b1 ||
                  dataD.ctl.regwrite !== 1'b0 || dataD.ctl.mem_size !== 2'd3) begin
      errors++; $display("FAIL sd got=op%0d imm%h mw%b rw%b sz%0d exp=op%0d imm8 mw1 rw0 sz3",
                         dataD.op, dataD.imm, dataD.ctl.mem_write, dataD.ctl.regwrite, dataD.ctl.mem_size, OP_SD); end

    put(64'h1014, 32'hFE208EE3, 1'b1);   // beq x1,x2,-4
    step();
    checks++; if (dataD.op !== OP_BEQ || dataD.imm !== 64'hFFFF_FFFF_FFFF_FFFC || dataD.ctl.regwrite !== 1'b0) begin
      errors++; $display("FAIL beq got=op%0d imm%h rw%b exp=op%0d immfffffffffffffffc rw0", dataD.op, dataD.imm, dataD.ctl.regwrite, OP_BEQ); end
  endtask

  task automatic test_load_use();
    int stall_cycles = 0;
    put(64'h2000, 32'h0000B283, 1'b1);   // ld x5,0(x1)
    step();
    checks++; if (dataD.op !== OP_LD || dataD.ctl.mem_read !== 1'b1 || dataD.dst !== 5'd5) begin
      errors++; $display("FAIL ld got=op%0d mr%b dst%0d exp=op%0d mr1 dst5", dataD.op, dataD.ctl.mem_read, dataD.dst, OP_LD); end
    put(64'h2004, 32'h00528333, 1'b1);   // add x6,x5,x5
    if (stopd === 1'b1) stall_cycles++;
    checks++; if (stopd !== 1'b1) begin errors++; $display("FAIL lu_stopd got=%b exp=1", stopd); end
    step();
    checks++; if (dataD.valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", dataD.valid); end
    if (stopd === 1'b1) stall_cycles++;
    step();
    checks++; if (stall_cycles !== 1) begin errors++; $display("FAIL lu_stall_len got=%0d exp=1", stall_cycles); end
    checks++; if (dataD.valid !== 1'b1 || dataD.op !== OP_ADD || dataD.dst !== 5'd6) begin
      errors++; $display("FAIL lu_add got=v%b op%0d dst%0d exp=v1 op%0d dst6", dataD.valid, dataD.op, dataD.dst, OP_ADD); end
  endtask

  task automatic test_branch();
    put(64'h3000, 32'h00500093, 1'b1);
    branch = 1'b1;
    step();
    branch = 1'b0;
    checks++; if (dataD.valid !== 1'b0) begin errors++; $display("FAIL br_flush got=%b exp=0", dataD.valid); end
    put(64'h3004, 32'h0000B283, 1'b1);
    step();
    put(64'h3008, 32'h00528333, 1'b1);
    branch = 1'b1; #1;
    checks++; if (stopd !== 1'b0) begin errors++; $display("FAIL br_lu_stopd got=%b exp=0", stopd); end
    step();
    branch = 1'b0;
    checks++; if (dataD.valid !== 1'b0) begin errors++; $display("FAIL br_lu_flush got=%b exp=0", dataD.valid); end
  endtask

  task automatic test_hold();
    decode_data_t snap;
    put(64'h4000, 32'h00500093, 1'b1);
    step();
    snap = dataD;
    stopm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(64'h4100 + 64'(i * 4), 32'h12345137, 1'b1);
      step();
      checks++; if (dataD !== snap) begin errors++; $display("FAIL hold_%0d got=%h exp=%h", i, dataD, snap); end
    end
    stopm = 1'b0;
    step();
    checks++; if (dataD.pc !== 64'h4108 || dataD.op !== OP_LUI || dataD.valid !== 1'b1) begin
      errors++; $display("FAIL hold_release got=pc%h op%0d v%b exp=pc4108 op%0d v1", dataD.pc, dataD.op, dataD.valid, OP_LUI); end
  endtask

  task automatic test_illegal();
    put(64'h5000, 32'hFFFFFFFF, 1'b1);
    step();
    checks++; if (dataD.op !== OP_UNKNOWN || dataD.ctl.regwrite !== 1'b0 || dataD.ctl.mem_read !== 1'b0 ||
                  dataD.ctl.mem_write !== 1'b0 || dataD.valid !== 1'b1) begin
      errors++; $display("FAIL illegal got=op%0d rw%b mr%b mw%b v%b exp=op0 rw0 mr0 mw0 v1",
                         dataD.op, dataD.ctl.regwrite, dataD.ctl.mem_read, dataD.ctl.mem_write, dataD.valid); end
    put(64'h5004, 32'h00100013, 1'b1);   // addi x0,x0,1
    step();
    checks++; if (dataD.op !== OP_ADDI || dataD.ctl.regwrite !== 1'b0) begin
      errors++; $display("FAIL x0_write got=op%0d rw%b exp=op%0d rw0", dataD.op, dataD.ctl.regwrite, OP_ADDI); end
  endtask

  task automatic test_reset_mid();
    put(64'h6000, 32'h0000B283, 1'b1);
    step();
    put(64'h6004, 32'h00528333, 1'b1);
    stope = 1'b1;
    step();
    checks++; if (stopd !== 1'b1 || dataD.op !== OP_LD || dataD.valid !== 1'b1) begin
      errors++; $display("FAIL stall_lu_hold got=stopd%b op%0d v%b exp=stopd1 op%0d v1", stopd, dataD.op, dataD.valid, OP_LD); end
    reset = 1'b1;
    step();
    reset = 1'b0; stope = 1'b0;
    checks++; if (dataD.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", dataD.valid); end
    checks++; if (stopd !== 1'b0) begin errors++; $display("FAIL rst_mid_stopd got=%b exp=0", stopd); end
  endtask

  initial begin
    reset = 1'b1; branch = 1'b0; stope = 1'b0; stopm = 1'b0;
    rd1 = '0; rd2 = '0; dataF = '0;
    test_reset();
    test_imm();
    test_load_use();
    test_branch();
    test_hold();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
